// File: rtl/iq_demod_pkg.sv
// Shared types and constants for the IQ demodulating accumulator.
// Holds the FSM state enum, default widths and the excitation period length.
package iq_demod_pkg;

    localparam int ACC_W_DEF          = 16;
    localparam int PER_W_DEF          = 8;
    localparam int SAMPLES_PER_PERIOD = 8;
    localparam int SPP_LOG2           = $clog2(SAMPLES_PER_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/iq_sample_counter.sv
// Sample counter for one measurement with a terminal-count flag.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i clears the
// count (wins over inc_i); inc_i counts one accumulated sample; target_i is
// the total number of samples; tc_o is high while the count is one short of
// target_i, i.e. the sample being taken this cycle is the last one.
module iq_sample_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == (target_i - CNT_W'(1)));

endmodule

// File: rtl/iq_demod_accum.sv
// Synchronous IQ demodulator: correlates a 1-bit comparator stream against
// in-phase/quadrature references over NumPeriods excitation periods.
// Ports: Clk, Resetn (async active-low); Start, Abort, NumPeriods control a
// measurement; CompIn, IP, QP are the sample and reference bits;
// CountEnable gates the excitation; AccI/AccQ are the signed results,
// Valid pulses for one cycle when they are final; Busy flags SYNC/ACCUM.
module iq_demod_accum
    import iq_demod_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Abort,
    input  logic [PER_W-1:0] NumPeriods,
    input  logic             CompIn,
    input  logic             IP,
    input  logic             QP,
    output logic             CountEnable,
    output logic [ACC_W-1:0] AccI,
    output logic [ACC_W-1:0] AccQ,
    output logic             Valid,
    output logic             Busy
);

    localparam int CNT_W = PER_W + SPP_LOG2;

    // |sum| <= 8*(2^PER_W-1) must fit a signed ACC_W value, so no wrap.
    if (ACC_W < PER_W + 5) begin : g_acc_w_check
        $error("iq_demod_accum: ACC_W must be at least PER_W+5");
    end

    localparam logic signed [ACC_W-1:0] STEP_P = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] STEP_M = '1;

    state_e                  state_q;
    state_e                  state_d;
    logic [PER_W-1:0]        np_q;
    logic [PER_W-1:0]        np_d;
    logic                    ip_q;
    logic signed [ACC_W-1:0] acc_i_q;
    logic signed [ACC_W-1:0] acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q;
    logic signed [ACC_W-1:0] acc_q_d;

    logic                    boundary;
    logic signed [ACC_W-1:0] step_i;
    logic signed [ACC_W-1:0] step_q;
    logic                    cnt_clr;
    logic                    cnt_inc;
    logic                    cnt_tc;
    logic [CNT_W-1:0]        cnt_target;

    // Period starts where IP rises; phase of IP/QP is otherwise trusted.
    assign boundary = IP & ~ip_q;

    assign step_i = (CompIn == IP) ? STEP_P : STEP_M;
    assign step_q = (CompIn == QP) ? STEP_P : STEP_M;

    assign cnt_target = {np_q, SPP_LOG2'(0)};

    iq_sample_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i    (Clk),
        .rst_ni   (Resetn),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .target_i (cnt_target),
        .tc_o     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        np_d    = np_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start && (NumPeriods != '0)) begin
                    state_d = ST_SYNC;
                    np_d    = NumPeriods;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            ST_SYNC: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_clr = 1'b1;
                end else if (boundary) begin
                    state_d = ST_ACCUM;
                    acc_i_d = acc_i_q + step_i;
                    acc_q_d = acc_q_q + step_q;
                    cnt_inc = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_clr = 1'b1;
                end else begin
                    acc_i_d = acc_i_q + step_i;
                    acc_q_d = acc_q_q + step_q;
                    cnt_inc = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            np_q    <= '0;
            ip_q    <= 1'b0;
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            state_q <= state_d;
            np_q    <= np_d;
            ip_q    <= IP;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end

    assign Busy        = (state_q == ST_SYNC) || (state_q == ST_ACCUM);
    assign CountEnable = Busy;
    assign Valid       = (state_q == ST_DONE);
    assign AccI        = acc_i_q;
    assign AccQ        = acc_q_q;

endmodule

// File: tb/tb_iq_demod_accum.sv
// Directed testbench for iq_demod_accum.
// IP/QP come from a free-running 3-bit phase counter; CompIn is selectable.
module tb_iq_demod_accum;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Abort;
    logic [7:0]  NumPeriods;
    logic        CompIn;
    logic        IP;
    logic        QP;
    logic        CountEnable;
    logic [15:0] AccI;
    logic [15:0] AccQ;
    logic        Valid;
    logic        Busy;

    logic [2:0]  ph = 3'd0;
    logic [1:0]  mode;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) ph <= ph + 3'd1;

    assign IP = (ph < 3'd4);
    assign QP = (ph >= 3'd2) && (ph <= 3'd5);

    always_comb begin
        CompIn = 1'b0;
        case (mode)
            2'd0: CompIn = IP;
            2'd1: CompIn = QP;
            2'd2: CompIn = ~IP;
            default: CompIn = 1'b0;
        endcase
    end

    iq_demod_accum dut (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .Start       (Start),
        .Abort       (Abort),
        .NumPeriods  (NumPeriods),
        .CompIn      (CompIn),
        .IP          (IP),
        .QP          (QP),
        .CountEnable (CountEnable),
        .AccI        (AccI),
        .AccQ        (AccQ),
        .Valid       (Valid),
        .Busy        (Busy)
    );

    task automatic pulse_start(input logic [7:0] np);
        @(negedge Clk);
        Start      = 1'b1;
        NumPeriods = np;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    // Observe a run from its first SYNC cycle; swait counts SYNC cycles
    // before the IP rising edge (ph==0 as seen by the next clock edge).
    task automatic monitor(input int np, output int nval, output int nce,
                           output int swait, output logic [15:0] ri,
                           output logic [15:0] rq);
        bit seen_b;
        seen_b = 1'b0;
        nval   = 0;
        nce    = 0;
        swait  = 0;
        ri     = '0;
        rq     = '0;
        for (int c = 0; c < 8 * np + 24; c++) begin
            @(negedge Clk);
            if (CountEnable) begin
                nce++;
                if (!seen_b) begin
                    if (ph == 3'd0) seen_b = 1'b1;
                    else swait++;
                end
            end
            if (Valid) begin
                nval++;
                ri = AccI;
                rq = AccQ;
            end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (CountEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_ce got %b want 0", CountEnable);
        end
        checks++;
        if (Valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", Valid);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", Busy);
        end
        checks++;
        if (AccI !== 16'd0 || AccQ !== 16'd0) begin
            errors++;
            $display("FAIL reset_acc got %h/%h want 0/0", AccI, AccQ);
        end
        @(negedge Clk);
        @(negedge Clk);
        Resetn = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_in_phase;
        int nv, nce, sw;
        logic [15:0] ri, rq;
        mode = 2'd0;
        pulse_start(8'd4);
        monitor(4, nv, nce, sw, ri, rq);
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL ip_valid_count got %0d want 1", nv);
        end
        checks++;
        if (ri !== 16'd32 || rq !== 16'd0) begin
            errors++;
            $display("FAIL ip_result got %0d/%0d want 32/0",
                     $signed(ri), $signed(rq));
        end
        checks++;
        if (nce != sw + 32) begin
            errors++;
            $display("FAIL ip_ce_cycles got %0d want %0d", nce, sw + 32);
        end
        checks++;
        if (AccI !== 16'd32 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL ip_hold got %0d busy %b want 32 busy 0",
                     $signed(AccI), Busy);
        end
    endtask

    task automatic test_quadrature;
        int nv, nce, sw;
        logic [15:0] ri, rq;
        mode = 2'd1;
        pulse_start(8'd4);
        monitor(4, nv, nce, sw, ri, rq);
        checks++;
        if (nv != 1 || ri !== 16'd0 || rq !== 16'd32) begin
            errors++;
            $display("FAIL qp_result got v%0d %0d/%0d want v1 0/32",
                     nv, $signed(ri), $signed(rq));
        end
    endtask

    task automatic test_full_scale;
        int nv, nce, sw;
        logic [15:0] ri, rq;
        logic [15:0] exp_i;
        exp_i = -16'sd2040;
        mode  = 2'd2;
        pulse_start(8'd255);
        monitor(255, nv, nce, sw, ri, rq);
        checks++;
        if (nv != 1 || ri !== exp_i || rq !== 16'd0) begin
            errors++;
            $display("FAIL fullscale_result got v%0d %0d/%0d want v1 -2040/0",
                     nv, $signed(ri), $signed(rq));
        end
        checks++;
        if (nce != sw + 2040) begin
            errors++;
            $display("FAIL fullscale_ce got %0d want %0d", nce, sw + 2040);
        end
    endtask

    task automatic test_start_ignored;
        int nv, nce, sw;
        logic [15:0] ri, rq;
        mode = 2'd0;
        pulse_start(8'd2);
        fork
            monitor(2, nv, nce, sw, ri, rq);
            begin
                repeat (12) @(negedge Clk);
                Start      = 1'b1;
                NumPeriods = 8'd1;
                @(posedge Clk);
                #1;
                Start = 1'b0;
            end
        join
        checks++;
        if (nv != 1 || ri !== 16'd16 || rq !== 16'd0) begin
            errors++;
            $display("FAIL midstart_result got v%0d %0d/%0d want v1 16/0",
                     nv, $signed(ri), $signed(rq));
        end
        checks++;
        if (nce != sw + 16) begin
            errors++;
            $display("FAIL midstart_ce got %0d want %0d", nce, sw + 16);
        end
    endtask

    task automatic test_abort;
        int nv, nce, sw, nv1, waited;
        logic [15:0] ri, rq;
        mode   = 2'd0;
        nv1    = 0;
        waited = 0;
        pulse_start(8'd4);
        do begin
            @(negedge Clk);
            waited++;
            if (Valid) nv1++;
        end while (!(CountEnable && ph == 3'd0) && waited < 20);
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL abort_sync_timeout got %0d cycles want <20", waited);
        end
        repeat (10) begin
            @(negedge Clk);
            if (Valid) nv1++;
        end
        Abort = 1'b1;
        @(posedge Clk);
        #1;
        Abort = 1'b0;
        @(negedge Clk);
        if (Valid) nv1++;
        checks++;
        if (Busy !== 1'b0 || CountEnable !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy %b ce %b want 0 0",
                     Busy, CountEnable);
        end
        checks++;
        if (AccI !== 16'd0 || AccQ !== 16'd0) begin
            errors++;
            $display("FAIL abort_acc got %h/%h want 0/0", AccI, AccQ);
        end
        checks++;
        if (nv1 != 0) begin
            errors++;
            $display("FAIL abort_valid got %0d pulses want 0", nv1);
        end
        pulse_start(8'd4);
        monitor(4, nv, nce, sw, ri, rq);
        checks++;
        if (nv != 1 || ri !== 16'd32 || rq !== 16'd0) begin
            errors++;
            $display("FAIL abort_rerun got v%0d %0d/%0d want v1 32/0",
                     nv, $signed(ri), $signed(rq));
        end
    endtask

    task automatic test_reset_mid;
        int nv, nce, sw;
        logic [15:0] ri, rq;
        mode = 2'd0;
        pulse_start(8'd4);
        repeat (15) @(negedge Clk);
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || CountEnable !== 1'b0 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl got b%b c%b v%b want 000",
                     Busy, CountEnable, Valid);
        end
        checks++;
        if (AccI !== 16'd0 || AccQ !== 16'd0) begin
            errors++;
            $display("FAIL midreset_acc got %h/%h want 0/0", AccI, AccQ);
        end
        @(negedge Clk);
        Resetn = 1'b1;
        repeat (3) @(negedge Clk);
        pulse_start(8'd4);
        monitor(4, nv, nce, sw, ri, rq);
        checks++;
        if (nv != 1 || ri !== 16'd32 || rq !== 16'd0) begin
            errors++;
            $display("FAIL midreset_rerun got v%0d %0d/%0d want v1 32/0",
                     nv, $signed(ri), $signed(rq));
        end
    endtask

    task automatic test_zero_periods;
        int nbusy, nval;
        nbusy = 0;
        nval  = 0;
        pulse_start(8'd0);
        repeat (20) begin
            @(negedge Clk);
            if (Busy || CountEnable) nbusy++;
            if (Valid) nval++;
        end
        checks++;
        if (nbusy != 0 || nval != 0) begin
            errors++;
            $display("FAIL zero_periods got busy %0d valid %0d want 0 0",
                     nbusy, nval);
        end
        checks++;
        if (AccI !== 16'd32) begin
            errors++;
            $display("FAIL zero_periods_hold got %0d want 32", $signed(AccI));
        end
    endtask

    initial begin
        Resetn     = 1'b0;
        Start      = 1'b0;
        Abort      = 1'b0;
        NumPeriods = 8'd0;
        mode       = 2'd0;
        test_reset();
        test_in_phase();
        test_quadrature();
        test_full_scale();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_zero_periods();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_demod_accum.md
IQ_DEMOD_ACCUM -- requirements
Module: iq_demod_accum

Interface
REQ-001 Parameter ACC_W, default 16, width of the signed I and Q accumulators.
REQ-002 Parameter PER_W, default 8, width of the measurement-period count.
REQ-003 Clk  input  1  single clock for all state; rising-edge active.
REQ-004 Resetn  input  1  reset; asynchronous, active-low.
REQ-005 Start  input  1  single-cycle request to begin a measurement.
REQ-006 Abort  input  1  cancels any measurement in progress.
REQ-007 NumPeriods  input  PER_W  number of 8-Clk excitation periods to integrate; latched at Start.
REQ-008 CompIn  input  1  comparator decision bit, already synchronous to Clk.
REQ-009 IP  input  1  in-phase reference from the excitation counter; high for counter states 0-3.
REQ-010 QP  input  1  quadrature reference from the excitation counter; high for counter states 2-5.
REQ-011 CountEnable  output  1  excitation enable sent to the excitation counter / DAC.
REQ-012 AccI  output  ACC_W  signed in-phase correlation result.
REQ-013 AccQ  output  ACC_W  signed quadrature correlation result.
REQ-014 Valid  output  1  one-cycle pulse; AccI/AccQ are final.
REQ-015 Busy  output  1  high in SYNC and ACCUM.

Function
REQ-016 The FSM SHALL have the states IDLE, SYNC, ACCUM and DONE.
REQ-017 IDLE -> SYNC SHALL occur on Start=1 with NumPeriods!=0: latch NumPeriods, clear AccI/AccQ to 0 and clear the sample counter.
REQ-018 Start with NumPeriods==0, or Start in any non-IDLE state, SHALL be ignored.
REQ-019 A period boundary SHALL be the cycle where IP=1 and the registered IP of the previous cycle is 0.
REQ-020 In SYNC, the boundary cycle SHALL accumulate the first sample and move to ACCUM; non-boundary cycles accumulate nothing.
REQ-021 Each accumulated cycle: AccI += (CompIn==IP) ? +1 : -1, and AccQ += (CompIn==QP) ? +1 : -1.
REQ-022 ACCUM SHALL accumulate exactly 8*NumPeriods samples in total (SYNC boundary sample included), then go to DONE on the cycle after the last sample.
REQ-023 DONE SHALL last one cycle with Valid=1, then go to IDLE; AccI/AccQ hold their values until the next accepted Start.
REQ-024 CountEnable SHALL be 1 in SYNC and ACCUM and 0 in IDLE and DONE.
REQ-025 Abort=1 in SYNC or ACCUM SHALL go to IDLE next cycle with no Valid and AccI=AccQ=0; Abort SHALL have priority over Start and completion in the same cycle.
REQ-026 An elaboration check SHALL enforce ACC_W >= PER_W+5, so that the accumulators (|sum| <= 8*(2^PER_W-1)) never wrap; no saturation logic is required.
REQ-027 IP/QP phase SHALL NOT be checked; only the IP rising edge is used for alignment.

Reset
REQ-028 Resetn=0 SHALL force the following immediately, including during a measurement: state IDLE, AccI=AccQ=0, sample counter=0, latched NumPeriods=0, registered IP=0, CountEnable=0, Valid=0, Busy=0.
REQ-029 After release, the first IP rising edge SHALL be detected relative to the post-reset registered IP=0.

Structure
REQ-030 The package iq_demod_pkg SHALL hold the FSM state enum, the ACC_W/PER_W defaults and the SAMPLES_PER_PERIOD=8 constant.
REQ-031 The sample counter (width PER_W+3, with terminal-count flag) SHALL be a sub-module named iq_sample_counter; all other logic stays in iq_demod_accum.

Verification
REQ-032 CompIn tied to IP, NumPeriods=4, IP/QP from a free-running 3-bit counter -> one Valid pulse, AccI=+32, AccQ=0, CountEnable high for the SYNC wait plus 32 cycles.
REQ-033 CompIn tied to QP, NumPeriods=4 -> AccI=0, AccQ=+32.
REQ-034 CompIn=~IP, NumPeriods=255 -> AccI=-2040, AccQ=0, no wrap at ACC_W=16.
REQ-035 Abort after 10 ACCUM cycles, then a second Start one cycle later -> no Valid for the first run; the second run completes correctly; Start during ACCUM is ignored.
REQ-036 Resetn pulsed low mid-ACCUM -> all outputs 0 asynchronously; a new Start after release gives correct results.
REQ-037 Start with NumPeriods=0 -> state stays IDLE, Busy=0, no Valid.
